// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: buffers fetched {instr, pc} pairs for decode.
// Registered-only fetch_ready; flush discards everything in one edge.
module if_id_queue #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_valid,
  input  logic [31:0]                fetch_instr,
  input  logic [31:0]                fetch_pc,
  output logic                       fetch_ready,
  input  logic                       flush,
  input  logic                       id_ready,
  output logic                       id_valid,
  output logic [31:0]                id_instr,
  output logic [31:0]                id_pc,
  output logic [31:0]                id_pc_plus4,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       push_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_ent_t;

  fetch_ent_t      mem_q [DEPTH];
  fetch_ent_t      head;

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push_err_q, push_err_d;

  logic            push;
  logic            pop;

  assign fetch_ready = (count_q < CW'(DEPTH));
  assign id_valid    = (count_q != '0);
  assign count       = count_q;
  assign push_err    = push_err_q;

  assign push = fetch_valid & fetch_ready & ~flush;
  assign pop  = id_valid & id_ready & ~flush;

  // Head is masked so stale storage never leaks while empty.
  assign head        = mem_q[rd_ptr_q];
  assign id_instr    = id_valid ? head.instr : 32'h0000_0000;
  assign id_pc       = id_valid ? head.pc : 32'h0000_0000;
  assign id_pc_plus4 = id_valid ? head.pc + 32'd4 : 32'h0000_0000;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    push_err_d = push_err_q
               | (fetch_valid & ~fetch_ready & ~flush);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      push_err_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      push_err_q <= push_err_d;
    end
  end

  // Storage is data-only; validity lives entirely in count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{instr: fetch_instr, pc: fetch_pc};
    end
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter DEPTH, default 2, number of buffered fetch entries; power of two, minimum 2.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 fetch_valid  input  1  fetch stage presents a valid instruction/pc pair this cycle.
REQ-005 fetch_instr  input  32  instruction word from fetch stage.
REQ-006 fetch_pc  input  32  byte address of fetch_instr.
REQ-007 fetch_ready  output  1  queue accepts a push this cycle; fetch holds pc while low.
REQ-008 flush  input  1  taken-branch redirect (PCSrc); discards all queued and incoming entries.
REQ-009 id_ready  input  1  decode stage consumes the head entry this cycle.
REQ-010 id_valid  output  1  head entry valid.
REQ-011 id_instr  output  32  head instruction; 32'h00000000 (NOP) when id_valid low.
REQ-012 id_pc  output  32  head pc; 0 when id_valid low.
REQ-013 id_pc_plus4  output  32  id_pc + 4, modulo 2^32; 0 when id_valid low.
REQ-014 count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 push_err  output  1  sticky flag: fetch_valid asserted while fetch_ready low.

Function
REQ-016 push = fetch_valid & fetch_ready & ~flush; pop = id_valid & id_ready & ~flush.
REQ-017 fetch_ready SHALL equal (count < DEPTH), derived from registered state only; no same-cycle dependency on id_ready.
REQ-018 On push, {fetch_instr, fetch_pc} written at write pointer; write pointer advances by 1, wrapping DEPTH-1 -> 0.
REQ-019 On pop, read pointer advances by 1, wrapping DEPTH-1 -> 0.
REQ-020 count next = count + push - pop; simultaneous push and pop leave count unchanged.
REQ-021 Latency: entry pushed in cycle N appears at head (id_valid high) no earlier than cycle N+1; no combinational bypass.
REQ-022 id_valid = (count != 0); id_instr/id_pc from read-pointer entry, held stable while id_valid & ~id_ready.
REQ-023 Entries leave in push order (FIFO); no reordering or duplication.
REQ-024 Full (count = DEPTH): fetch_ready low; a pop that cycle takes effect; fetch_ready rises next cycle.
REQ-025 Empty (count = 0): id_ready ignored; outputs forced to NOP/zero values.
REQ-026 flush high: next cycle count = 0, both pointers = 0, id_valid low; push and pop suppressed that cycle; flush has priority over all other events.
REQ-027 push_err set on any cycle with fetch_valid & ~fetch_ready & ~flush; cleared only by reset.
REQ-028 id_pc_plus4 wrap: id_pc 32'hFFFFFFFC yields 32'h00000000.
REQ-029 Storage contents not reset-dependent beyond invalidation; stale entries never visible with id_valid low.

Reset
REQ-030 While reset high, regardless of clk: count = 0, pointers = 0, id_valid = 0, id_instr = 0, id_pc = 0, id_pc_plus4 = 0, push_err = 0, fetch_ready = 1.
REQ-031 Reset asserted mid-operation discards all entries immediately; first edge after deassertion behaves as empty queue.

Verification
REQ-032 Single push: fetch_valid=1, instr 32'h20080005, pc 0, id_ready=0 -> next cycle id_valid=1, id_instr=32'h20080005, id_pc=0, id_pc_plus4=4, count=1.
REQ-033 Fill and backpressure: DEPTH=2, push pc 0,4, id_ready=0 -> count=2, fetch_ready=0; extra fetch_valid -> push_err=1, entries unchanged; release id_ready -> pops pc 0 then 4 in order.
REQ-034 Streaming: fetch_valid=1, id_ready=1 every cycle, pcs 0,4,8,... -> count stays 1 after first cycle, id_pc increments by 4 per cycle, no drops.
REQ-035 Flush: count=2, flush=1 with fetch_valid=1 pc 32'h40 -> next cycle count=0, id_valid=0, id_instr=0; pc 32'h40 not queued.
REQ-036 Wrap: push pc 32'hFFFFFFFC -> id_pc_plus4=0; pointer wraparound over 3×DEPTH pushes/pops keeps order intact.
REQ-037 Async reset: assert reset between clock edges with count=2 -> outputs at reset values before next edge.
